// File: rtl/spi_memory_fsm.sv
// SPI-slave control FSM for the lab SPI memory: decodes a 7-bit address plus R/W
// command from conditioned SPI signals and reads/writes one byte of internal memory.
module spi_memory_fsm #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_cond,
    input  logic       sclk_posedge,
    input  logic       sclk_negedge,
    input  logic       mosi_cond,
    output logic       miso_out,
    output logic       miso_en,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_GET_ADDR     = 3'd1;
    localparam logic [2:0] S_READ_LOAD    = 3'd2;
    localparam logic [2:0] S_READ_SHIFT   = 3'd3;
    localparam logic [2:0] S_WRITE_SHIFT  = 3'd4;
    localparam logic [2:0] S_WRITE_COMMIT = 3'd5;
    localparam logic [2:0] S_DONE         = 3'd6;

    localparam logic [3:0] CMD_LAST  = 4'(ADDR_WIDTH);
    localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] CNT_MAX   = 4'(DATA_WIDTH);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cmd_sr_q, cmd_sr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            rx_cnt_q, rx_cnt_d;
    logic [3:0]            tx_cnt_q, tx_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  miso_q, miso_d;
    logic                  miso_en_q, miso_en_d;

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  mem_we;
    logic                  pos;
    logic                  neg;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 4'd1;
    endfunction

    // A negedge coinciding with a posedge is dropped; the posedge wins.
    assign pos     = sclk_posedge;
    assign neg     = sclk_negedge & ~sclk_posedge;
    assign rd_data = mem[addr_q];

    always_comb begin
        state_d   = state_q;
        cmd_sr_d  = cmd_sr_q;
        addr_d    = addr_q;
        rx_cnt_d  = rx_cnt_q;
        tx_cnt_d  = tx_cnt_q;
        shift_d   = shift_q;
        miso_d    = miso_q;
        miso_en_d = miso_en_q;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_sr_d  = '0;
                rx_cnt_d  = '0;
                tx_cnt_d  = '0;
                miso_d    = 1'b0;
                miso_en_d = 1'b0;
                if (!cs_cond) state_d = S_GET_ADDR;
            end

            S_GET_ADDR: begin
                if (cs_cond) begin
                    state_d   = S_IDLE;
                    miso_en_d = 1'b0;
                    miso_d    = 1'b0;
                end else if (pos) begin
                    rx_cnt_d = sat_inc(rx_cnt_q);
                    // The eighth bit is R/W and is taken straight from MOSI.
                    if (rx_cnt_q == CMD_LAST) begin
                        addr_d   = cmd_sr_q;
                        rx_cnt_d = '0;
                        state_d  = mosi_cond ? S_READ_LOAD : S_WRITE_SHIFT;
                    end else begin
                        cmd_sr_d = {cmd_sr_q[ADDR_WIDTH-2:0], mosi_cond};
                    end
                end
            end

            S_READ_LOAD: begin
                if (cs_cond) begin
                    state_d   = S_IDLE;
                    miso_en_d = 1'b0;
                    miso_d    = 1'b0;
                end else begin
                    miso_d    = rd_data[DATA_WIDTH-1];
                    shift_d   = rd_data << 1;
                    tx_cnt_d  = 4'd1;
                    miso_en_d = 1'b1;
                    state_d   = S_READ_SHIFT;
                end
            end

            S_READ_SHIFT: begin
                if (cs_cond) begin
                    state_d   = S_IDLE;
                    miso_en_d = 1'b0;
                    miso_d    = 1'b0;
                end else if (pos) begin
                    rx_cnt_d = sat_inc(rx_cnt_q);
                    if (rx_cnt_q == DATA_LAST) begin
                        state_d   = S_DONE;
                        miso_en_d = 1'b0;
                        miso_d    = 1'b0;
                    end
                end else if (neg && (tx_cnt_q < CNT_MAX)) begin
                    miso_d   = shift_q[DATA_WIDTH-1];
                    shift_d  = shift_q << 1;
                    tx_cnt_d = sat_inc(tx_cnt_q);
                end
            end

            S_WRITE_SHIFT: begin
                // CS high wins even over the final data bit, so no partial write lands.
                if (cs_cond) begin
                    state_d   = S_IDLE;
                    miso_en_d = 1'b0;
                    miso_d    = 1'b0;
                end else if (pos) begin
                    shift_d  = {shift_q[DATA_WIDTH-2:0], mosi_cond};
                    rx_cnt_d = sat_inc(rx_cnt_q);
                    if (rx_cnt_q == DATA_LAST) state_d = S_WRITE_COMMIT;
                end
            end

            S_WRITE_COMMIT: begin
                mem_we   = 1'b1;
                rx_cnt_d = '0;
                state_d  = S_DONE;
            end

            S_DONE: begin
                if (cs_cond) state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                miso_en_d = 1'b0;
                miso_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cmd_sr_q  <= '0;
            addr_q    <= '0;
            rx_cnt_q  <= '0;
            tx_cnt_q  <= '0;
            shift_q   <= '0;
            miso_q    <= 1'b0;
            miso_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_sr_q  <= cmd_sr_d;
            addr_q    <= addr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
            shift_q   <= shift_d;
            miso_q    <= miso_d;
            miso_en_q <= miso_en_d;
        end
    end

    // Memory array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= shift_q;
    end

    assign miso_out = miso_q;
    assign miso_en  = miso_en_q;
    assign state    = state_q;

endmodule

// File: tb/tb_spi_memory_fsm.sv
// Scoreboard bench for spi_memory_fsm: a byte-array reference memory predicts read data,
// a monitor compares each MISO bit presented while the slave drives the line.
module tb_spi_memory_fsm;

    localparam int GAP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_cond = 1'b1;
    logic       sclk_posedge = 1'b0;
    logic       sclk_negedge = 1'b0;
    logic       mosi_cond = 1'b0;
    logic       miso_out;
    logic       miso_en;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    logic       exp_q[$];
    logic [7:0] ref_mem [0:127];
    logic [6:0] wlist[$];

    always #5 clk = ~clk;

    spi_memory_fsm #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs_cond      (cs_cond),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .mosi_cond    (mosi_cond),
        .miso_out     (miso_out),
        .miso_en      (miso_en),
        .state        (state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pulse_pos(input logic b);
        mosi_cond = b;
        sclk_posedge = 1'b1;
        tick();
        sclk_posedge = 1'b0;
        repeat (GAP) tick();
    endtask

    task automatic pulse_neg();
        sclk_negedge = 1'b1;
        tick();
        sclk_negedge = 1'b0;
        repeat (GAP) tick();
    endtask

    task automatic send_cmd(input logic [6:0] a, input logic rw);
        cs_cond = 1'b0;
        repeat (2) tick();
        for (int i = 6; i >= 0; i--) begin
            pulse_pos(a[i]);
            pulse_neg();
        end
        mosi_cond = rw;
        sclk_posedge = 1'b1;
        tick();
        sclk_posedge = 1'b0;
        check("cmd_decode_state", state, rw ? 2 : 4);
        tick();
        if (rw) check("read_miso_en_latency", miso_en, 1);
        repeat (GAP - 1) tick();
        pulse_neg();
    endtask

    task automatic end_txn();
        cs_cond = 1'b1;
        tick();
        check("idle_after_cs_high", state, 0);
        tick();
    endtask

    task automatic write_txn(input logic [6:0] a, input logic [7:0] d);
        send_cmd(a, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            pulse_pos(d[i]);
            pulse_neg();
        end
        check("write_done_state", state, 6);
        ref_mem[a] = d;
        wlist.push_back(a);
        end_txn();
    endtask

    task automatic read_txn(input logic [6:0] a, input int nclk);
        for (int i = 7; i >= 0; i--) exp_q.push_back(ref_mem[a][i]);
        send_cmd(a, 1'b1);
        for (int j = 0; j < nclk; j++) begin
            pulse_pos(1'b0);
            pulse_neg();
        end
        check("read_done_state", state, 6);
        check("read_done_miso_en", miso_en, 0);
        check("read_done_miso_out", miso_out, 0);
        check("read_bits_consumed", exp_q.size(), 0);
        end_txn();
    endtask

    // Monitor: every falling SCLK pulse while the slave drives MISO consumes one expected bit.
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            if (rst_n && sclk_negedge && miso_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL miso_extra_bit: got %0b, expected no driven bit (t=%0t)", miso_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (miso_out !== e) begin
                        bad++;
                        $display("FAIL miso_bit: got %0b, expected %0b (t=%0t)", miso_out, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] ra;
        logic [7:0] rd;

        repeat (3) tick();
        check("reset_state", state, 0);
        check("reset_miso_en", miso_en, 0);
        check("reset_miso_out", miso_out, 0);
        rst_n = 1'b1;
        tick();

        // Write then read back.
        write_txn(7'h2C, 8'hA5);
        read_txn(7'h2C, 8);

        // Address extremes.
        write_txn(7'h7F, 8'hFF);
        write_txn(7'h00, 8'h00);
        read_txn(7'h7F, 8);
        read_txn(7'h00, 8);

        // Write aborted after five data bits.
        write_txn(7'h10, 8'h3C);
        send_cmd(7'h10, 1'b0);
        rd = 8'hC3;
        for (int i = 7; i >= 3; i--) begin
            pulse_pos(rd[i]);
            pulse_neg();
        end
        cs_cond = 1'b1;
        tick();
        check("abort_write_state", state, 0);
        tick();
        read_txn(7'h10, 8);

        // CS rising in the same cycle as the eighth data posedge.
        write_txn(7'h22, 8'h55);
        send_cmd(7'h22, 1'b0);
        rd = 8'hAA;
        for (int i = 7; i >= 1; i--) begin
            pulse_pos(rd[i]);
            pulse_neg();
        end
        mosi_cond = rd[0];
        sclk_posedge = 1'b1;
        cs_cond = 1'b1;
        tick();
        sclk_posedge = 1'b0;
        check("abort_race_state", state, 0);
        repeat (GAP) tick();
        read_txn(7'h22, 8);

        // CS rising during the commit cycle still commits.
        send_cmd(7'h33, 1'b0);
        rd = 8'h96;
        for (int i = 7; i >= 1; i--) begin
            pulse_pos(rd[i]);
            pulse_neg();
        end
        mosi_cond = rd[0];
        sclk_posedge = 1'b1;
        tick();
        sclk_posedge = 1'b0;
        cs_cond = 1'b1;
        tick();
        check("commit_with_cs_state", state, 6);
        tick();
        check("commit_with_cs_idle", state, 0);
        ref_mem[7'h33] = rd;
        read_txn(7'h33, 8);

        // Async reset in the middle of a read after three bits.
        write_txn(7'h45, 8'h6D);
        for (int i = 7; i >= 5; i--) exp_q.push_back(ref_mem[7'h45][i]);
        send_cmd(7'h45, 1'b1);
        pulse_pos(1'b0);
        pulse_neg();
        pulse_pos(1'b0);
        pulse_neg();
        rst_n = 1'b0;
        #1;
        check("async_rst_miso_en", miso_en, 0);
        check("async_rst_miso_out", miso_out, 0);
        check("async_rst_state", state, 0);
        cs_cond = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("partial_read_bits_consumed", exp_q.size(), 0);
        read_txn(7'h45, 8);

        // Twelve SCLK cycles in the data phase; extras are ignored.
        read_txn(7'h2C, 12);

        // Randomized write/read traffic against the reference memory.
        for (int n = 0; n < 20; n++) begin
            ra = 7'($urandom_range(0, 127));
            rd = 8'($urandom);
            write_txn(ra, rd);
            ra = wlist[$urandom_range(0, wlist.size() - 1)];
            read_txn(ra, 8 + $urandom_range(0, 3));
        end

        repeat (5) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
